// File: rtl/mpx_retire_trace_pkg.sv
// Shared types and constants for the MPX retire trace capture stage.
// Holds FSM state encodings and the packed trace entry layout.
package mpx_retire_trace_pkg;

  typedef enum logic [1:0] {
    MPX_TRACE_STATE_DISABLED = 2'd0,
    MPX_TRACE_STATE_ACTIVE   = 2'd1,
    MPX_TRACE_STATE_DRAIN    = 2'd2
  } trace_state_e;

  localparam int unsigned MPX_TRACE_ENTRY_W = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] opcode;
  } trace_entry_t;

endpackage

// File: rtl/mpx_trace_fifo.sv
// Generic synchronous FIFO with a registered head output.
// Ports: clk_i/rst_i (sync, active-high), push_i/din_i write,
//   pop_i advance head, dout_o/valid_o registered head,
//   level_o occupancy 0..DEPTH, full_o/empty_o from level.
module mpx_trace_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic [LW-1:0]    remain;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == LW'(DEPTH));
  assign empty_o = (count_q == '0);

  always_comb begin
    push_ok  = push_i && (!full_o || pop_i);
    pop_ok   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + LW'(push_ok) - LW'(pop_ok);
    remain   = count_q - LW'(pop_ok);
    valid_d  = (count_d != '0);
    dout_d   = dout_q;
    // An entry that lands in an otherwise empty
    // FIFO bypasses the array so it shows next cycle.
    if (remain != '0) begin
      dout_d = mem_q[rd_ptr_d];
    end else if (push_ok) begin
      dout_d = din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
    end
  end

  assign dout_o  = dout_q;
  assign valid_o = valid_q;
  assign level_o = count_q;

endmodule

// File: rtl/mpx_retire_trace.sv
// Retire trace capture: FIFO between retire point and trace decoder.
// Ports: clk_i/rst_i, enable_i, retire_* in, trace_* out with
//   trace_ready_i, stall_o, dropped_o, level_o, busy_o.
// Option: MPX_RETIRE_TRACE_STALL_EN drives stall_o when full.
module mpx_retire_trace
  import mpx_retire_trace_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DROP_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   retire_valid_i,
  input  logic [31:0]            retire_pc_i,
  input  logic [31:0]            retire_opcode_i,
  output logic                   trace_valid_o,
  output logic [31:0]            trace_pc_o,
  output logic [31:0]            trace_opcode_o,
  input  logic                   trace_ready_i,
  output logic                   stall_o,
  output logic [DROP_W-1:0]      dropped_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   busy_o
);

  trace_state_e      state_q, state_d;
  logic [DROP_W-1:0] dropped_q, dropped_d;
  trace_entry_t      din, dout;
  logic              push, pop, drop;
  logic              full, empty;

  assign din.pc     = retire_pc_i;
  assign din.opcode = retire_opcode_i;

  mpx_trace_fifo #(
    .WIDTH (MPX_TRACE_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .din_i   (din),
    .pop_i   (pop),
    .dout_o  (dout),
    .valid_o (trace_valid_o),
    .level_o (level_o),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    push = (state_q == MPX_TRACE_STATE_ACTIVE)
           && retire_valid_i;
    pop  = trace_valid_o && trace_ready_i;
    // A pop in the same cycle frees the slot.
    drop = push && full && !pop;
  end

  always_comb begin
    state_d   = state_q;
    dropped_d = dropped_q;
    unique case (state_q)
      MPX_TRACE_STATE_DISABLED: begin
        if (enable_i) begin
          state_d   = MPX_TRACE_STATE_ACTIVE;
          dropped_d = '0;
        end
      end
      MPX_TRACE_STATE_ACTIVE: begin
        if (!enable_i) begin
          state_d = MPX_TRACE_STATE_DRAIN;
        end
        if (drop && (dropped_q != '1)) begin
          dropped_d = dropped_q + 1'b1;
        end
      end
      MPX_TRACE_STATE_DRAIN: begin
        if (enable_i) begin
          state_d = MPX_TRACE_STATE_ACTIVE;
        end else if (empty) begin
          state_d = MPX_TRACE_STATE_DISABLED;
        end
      end
      default: begin
        state_d = MPX_TRACE_STATE_DISABLED;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= MPX_TRACE_STATE_DISABLED;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      dropped_q <= dropped_d;
    end
  end

`ifdef MPX_RETIRE_TRACE_STALL_EN
  assign stall_o = (state_q == MPX_TRACE_STATE_ACTIVE)
                   && full && !pop;

  // Retiring while stalled breaks the lossless contract.
  a_no_retire_on_stall : assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(retire_valid_i && stall_o)
  );
`else
  assign stall_o = 1'b0;
`endif

  assign trace_pc_o     = dout.pc;
  assign trace_opcode_o = dout.opcode;
  assign dropped_o      = dropped_q;
  assign busy_o = (state_q != MPX_TRACE_STATE_DISABLED);

endmodule

// File: tb/tb_mpx_retire_trace.sv
// Directed self-checking bench for mpx_retire_trace.
// Steps through capture, overflow, drain, saturation and reset.
module tb_mpx_retire_trace;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic        retire_valid_i;
  logic [31:0] retire_pc_i;
  logic [31:0] retire_opcode_i;
  logic        trace_valid_o;
  logic [31:0] trace_pc_o;
  logic [31:0] trace_opcode_o;
  logic        trace_ready_i;
  logic        stall_o;
  logic [15:0] dropped_o;
  logic [3:0]  level_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mpx_retire_trace #(
    .DEPTH  (8),
    .DROP_W (16)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .enable_i        (enable_i),
    .retire_valid_i  (retire_valid_i),
    .retire_pc_i     (retire_pc_i),
    .retire_opcode_i (retire_opcode_i),
    .trace_valid_o   (trace_valid_o),
    .trace_pc_o      (trace_pc_o),
    .trace_opcode_o  (trace_opcode_o),
    .trace_ready_i   (trace_ready_i),
    .stall_o         (stall_o),
    .dropped_o       (dropped_o),
    .level_o         (level_o),
    .busy_o          (busy_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] exp_drop;
    rst_i           = 1'b1;
    enable_i        = 1'b0;
    retire_valid_i  = 1'b0;
    retire_pc_i     = '0;
    retire_opcode_i = '0;
    trace_ready_i   = 1'b0;
    step();
    step();
    chk("rst_valid", 64'(trace_valid_o), 64'd0);
    chk("rst_pc", 64'(trace_pc_o), 64'd0);
    chk("rst_op", 64'(trace_opcode_o), 64'd0);
    chk("rst_level", 64'(level_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_drop", 64'(dropped_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    rst_i = 1'b0;
    step();
    chk("idle_busy", 64'(busy_o), 64'd0);

    // 1: single capture, one-cycle latency
    enable_i = 1'b1;
    step();
    chk("en_busy", 64'(busy_o), 64'd1);
    retire_valid_i  = 1'b1;
    retire_pc_i     = 32'hBFC0_0000;
    retire_opcode_i = 32'h3C08_0013;
    trace_ready_i   = 1'b1;
    step();
    retire_valid_i = 1'b0;
    chk("t1_valid", 64'(trace_valid_o), 64'd1);
    chk("t1_pc", 64'(trace_pc_o), 64'hBFC0_0000);
    chk("t1_op", 64'(trace_opcode_o), 64'h3C08_0013);
    chk("t1_level", 64'(level_o), 64'd1);
    step();
    chk("t1_valid0", 64'(trace_valid_o), 64'd0);
    chk("t1_level0", 64'(level_o), 64'd0);
    chk("t1_hold", 64'(trace_pc_o), 64'hBFC0_0000);

    // 2: fill to full with consumer stalled
    trace_ready_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      retire_valid_i  = 1'b1;
      retire_pc_i     = 32'h8000_0000 + 32'(4 * k);
      retire_opcode_i = 32'(k);
      step();
    end
    retire_valid_i = 1'b0;
    chk("t2_level", 64'(level_o), 64'd8);
    chk("t2_valid", 64'(trace_valid_o), 64'd1);
    chk("t2_head", 64'(trace_pc_o), 64'h8000_0000);
`ifdef MPX_RETIRE_TRACE_STALL_EN
    chk("t2_stall", 64'(stall_o), 64'd1);
    exp_drop = 16'd0;
`else
    chk("t2_stall", 64'(stall_o), 64'd0);
    retire_valid_i  = 1'b1;
    retire_pc_i     = 32'h8000_0020;
    retire_opcode_i = 32'd8;
    step();
    retire_valid_i = 1'b0;
    exp_drop = 16'd1;
    chk("t2_level9", 64'(level_o), 64'd8);
`endif
    chk("t2_drop", 64'(dropped_o), 64'(exp_drop));

    // 3: full with push and pop together
    retire_valid_i  = 1'b1;
    retire_pc_i     = 32'h8000_0020;
    retire_opcode_i = 32'd8;
    trace_ready_i   = 1'b1;
    step();
    retire_valid_i = 1'b0;
    chk("t3_level", 64'(level_o), 64'd8);
    chk("t3_drop", 64'(dropped_o), 64'(exp_drop));
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("t3_pc%0d", k), 64'(trace_pc_o),
          64'(32'h8000_0000 + 32'(4 * k)));
      step();
    end
    chk("t3_empty", 64'(trace_valid_o), 64'd0);
    chk("t3_level0", 64'(level_o), 64'd0);

    // 4: drain on disable, then re-enable in drain
    trace_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      retire_valid_i = 1'b1;
      retire_pc_i    = 32'h100 + 32'(4 * k);
      step();
    end
    retire_valid_i = 1'b0;
    chk("t4_level3", 64'(level_o), 64'd3);
    enable_i = 1'b0;
    step();
    chk("t4_drain", 64'(busy_o), 64'd1);
    retire_valid_i = 1'b1;
    retire_pc_i    = 32'hDEAD;
    trace_ready_i  = 1'b1;
    step();
    chk("t4_ign", 64'(level_o), 64'd2);
    chk("t4_pc1", 64'(trace_pc_o), 64'h104);
    step();
    chk("t4_pc2", 64'(trace_pc_o), 64'h108);
    step();
    retire_valid_i = 1'b0;
    chk("t4_lvl0", 64'(level_o), 64'd0);
    chk("t4_val0", 64'(trace_valid_o), 64'd0);
    step();
    chk("t4_off", 64'(busy_o), 64'd0);
    enable_i      = 1'b1;
    trace_ready_i = 1'b0;
    step();
    chk("t4_clr", 64'(dropped_o), 64'd0);
    for (int k = 0; k < 2; k++) begin
      retire_valid_i = 1'b1;
      retire_pc_i    = 32'h200 + 32'(4 * k);
      step();
    end
    retire_valid_i = 1'b0;
    enable_i       = 1'b0;
    step();
    enable_i = 1'b1;
    step();
    retire_valid_i = 1'b1;
    retire_pc_i    = 32'h208;
    step();
    retire_valid_i = 1'b0;
    chk("t4_re_lvl", 64'(level_o), 64'd3);
    trace_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t4_re_pc%0d", k), 64'(trace_pc_o),
          64'(32'h200 + 32'(4 * k)));
      step();
    end
    chk("t4_re_end", 64'(trace_valid_o), 64'd0);

`ifndef MPX_RETIRE_TRACE_STALL_EN
    // 5: drop counter saturation and clear
    trace_ready_i  = 1'b0;
    retire_valid_i = 1'b1;
    retire_pc_i    = 32'h300;
    repeat (8 + 65536 + 5) step();
    retire_valid_i = 1'b0;
    chk("t5_sat", 64'(dropped_o), 64'hFFFF);
    chk("t5_level", 64'(level_o), 64'd8);
    enable_i      = 1'b0;
    trace_ready_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (!busy_o) break;
      step();
    end
    chk("t5_idle", 64'(busy_o), 64'd0);
    chk("t5_hold", 64'(dropped_o), 64'hFFFF);
    enable_i = 1'b1;
    step();
    chk("t5_clr", 64'(dropped_o), 64'd0);
    chk("t5_busy", 64'(busy_o), 64'd1);
`endif

    // 6: reset mid-operation discards contents
    enable_i      = 1'b1;
    trace_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      retire_valid_i  = 1'b1;
      retire_pc_i     = 32'h400 + 32'(4 * k);
      retire_opcode_i = 32'h55;
      step();
    end
    retire_valid_i = 1'b0;
    chk("t6_level5", 64'(level_o), 64'd5);
    rst_i = 1'b1;
    step();
    chk("t6_valid", 64'(trace_valid_o), 64'd0);
    chk("t6_level", 64'(level_o), 64'd0);
    chk("t6_busy", 64'(busy_o), 64'd0);
    chk("t6_pc", 64'(trace_pc_o), 64'd0);
    chk("t6_op", 64'(trace_opcode_o), 64'd0);
    chk("t6_drop", 64'(dropped_o), 64'd0);
    chk("t6_stall", 64'(stall_o), 64'd0);
    rst_i = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
